// File: rtl/dm_responder.sv
// dm_responder: 4 KB word/byte memory slave, fixed LATENCY req->ack.
// clk/reset(async low); req,we,byte_en,addr,wdata in; ready,ack,rdata,err out.
module dm_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        fire;

  logic        we_q;
  logic        be_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;

  logic        op_we;
  logic        op_be;
  logic [11:0] op_addr;
  logic [31:0] op_wdata;
  logic        mis;
  logic        mem_we;
  logic [AW-1:0] idx;
  logic [31:0] cur;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [31:0] rd_n;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            fire    = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With LATENCY=1 the access completes on the accept
  // edge, before the capture registers hold it.
  always_comb begin
    if (state == IDLE) begin
      op_we    = we;
      op_be    = byte_en;
      op_addr  = addr;
      op_wdata = wdata;
    end else begin
      op_we    = we_q;
      op_be    = be_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign idx = AW'({22'd0, op_addr[11:2]}
             % 32'(DEPTH_WORDS));
  assign cur = mem[idx];
  assign mis = !op_be && (op_addr[1:0] != 2'b00);
  assign mem_we = fire && op_we && !mis && reset;

  always_comb begin
    merged = cur;
    lane_b = cur[7:0];
    unique case (op_addr[1:0])
      2'd0: begin
        lane_b       = cur[7:0];
        merged[7:0]  = op_wdata[7:0];
      end
      2'd1: begin
        lane_b       = cur[15:8];
        merged[15:8] = op_wdata[7:0];
      end
      2'd2: begin
        lane_b        = cur[23:16];
        merged[23:16] = op_wdata[7:0];
      end
      default: begin
        lane_b        = cur[31:24];
        merged[31:24] = op_wdata[7:0];
      end
    endcase
    if (!op_be) begin
      merged = op_wdata;
    end
  end

  always_comb begin
    rd_n = '0;
    unique case (1'b1)
      (mis || op_we):
        rd_n = '0;
      (!mis && !op_we && op_be):
        rd_n = {24'd0, lane_b};
      (!mis && !op_we && !op_be):
        rd_n = cur;
      default:
        rd_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        we_q    <= we;
        be_q    <= byte_en;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      rdata <= fire ? rd_n : '0;
      err   <= fire ? mis : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= merged;
    end
  end

  assign ready = (state == IDLE);
  assign ack   = (state == RESP);

endmodule
